// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter byte port; grant-to-tx_start latency 1 cycle, up to BURST_LEN bytes per grant.
// Sources hold req_valid until the one-cycle req_ready pulse; tx_busy stalls everything. Option: UART_TX_ARB_TAG_EN (tag byte per grant).
module uart_tx_arbiter #(
    parameter int          NUM_REQ   = 4,
    parameter int          IDW       = 3,
    parameter int          BURST_LEN = 1,
    parameter logic [7:0]  TAG_BASE  = 8'hF0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*8-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    input  logic                   tx_busy,
    output logic [IDW-1:0]         grant_id,
    output logic                   active
);

`ifdef UART_TX_ARB_TAG_EN
    typedef enum logic [2:0] {IDLE, START, DRAIN, TAG, TAGWAIT} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DRAIN} state_t;
`endif

    localparam logic [3:0] BURST_MAX = 4'(BURST_LEN);

    state_t               state;
    logic [IDW-1:0]       rr_ptr;
    logic [3:0]           burst_cnt;

    logic                 win_found;
    logic [IDW-1:0]       win_idx;
    logic [7:0]           win_data;
    logic [NUM_REQ-1:0]   win_onehot;
    logic                 cur_valid;
    logic [7:0]           cur_data;
    logic [NUM_REQ-1:0]   cur_onehot;
    logic [IDW-1:0]       next_ptr;

    // Scan offsets from farthest to nearest so the nearest valid index at or after rr_ptr wins.
    always_comb begin
        int j;
        j         = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int n = NUM_REQ - 1; n >= 0; n--) begin
            j = (int'(rr_ptr) + n) % NUM_REQ;
            if (req_valid[j]) begin
                win_found = 1'b1;
                win_idx   = IDW'(j);
            end
        end
    end

    always_comb begin
        win_data   = req_data[8*int'(win_idx) +: 8];
        win_onehot = NUM_REQ'(1) << win_idx;
        cur_valid  = req_valid[grant_id];
        cur_data   = req_data[8*int'(grant_id) +: 8];
        cur_onehot = NUM_REQ'(1) << grant_id;
        next_ptr   = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + IDW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            req_ready <= '0;
            tx_start  <= 1'b0;
            tx_data   <= '0;
            grant_id  <= '0;
            active    <= 1'b0;
        end else begin
            tx_start  <= 1'b0;
            req_ready <= '0;
            case (state)
                IDLE: begin
                    if (win_found && !tx_busy) begin
                        grant_id  <= win_idx;
                        burst_cnt <= 4'd1;
                        active    <= 1'b1;
                        tx_start  <= 1'b1;
`ifdef UART_TX_ARB_TAG_EN
                        state     <= TAG;
                        tx_data   <= TAG_BASE | 8'(win_idx);
`else
                        state     <= START;
                        tx_data   <= win_data;
                        req_ready <= win_onehot;
`endif
                    end
                end
                START: begin
                    state <= DRAIN;
                end
`ifdef UART_TX_ARB_TAG_EN
                TAG: begin
                    state <= TAGWAIT;
                end
                TAGWAIT: begin
                    // The source is still holding its byte: it has not seen ready yet.
                    if (!tx_busy) begin
                        state     <= START;
                        tx_data   <= cur_data;
                        tx_start  <= 1'b1;
                        req_ready <= cur_onehot;
                    end
                end
`endif
                DRAIN: begin
                    if (!tx_busy) begin
                        if (cur_valid && (burst_cnt < BURST_MAX)) begin
                            state     <= START;
                            tx_data   <= cur_data;
                            tx_start  <= 1'b1;
                            req_ready <= cur_onehot;
                            burst_cnt <= burst_cnt + 4'd1;
                        end else begin
                            state  <= IDLE;
                            rr_ptr <= next_ptr;
                            active <= 1'b0;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboarded bench for uart_tx_arbiter with a behavioural 11-cycle UART transmitter per instance.
module tb_uart_tx_arbiter;

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] rdy;
        logic [2:0] gid;
    } exp_t;

`ifdef UART_TX_ARB_TAG_EN
    localparam int GRANT_GAP = 27;
`else
    localparam int GRANT_GAP = 14;
`endif
    localparam int BURST_GAP = 13;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [3:0]  rv   [2];
    logic [31:0] rd   [2];
    logic [3:0]  rdy  [2];
    logic        ts   [2];
    logic [7:0]  td   [2];
    logic [2:0]  gid  [2];
    logic        act  [2];
    logic        busy [2];
    logic        fb   [2];
    logic [3:0]  cnt  [2];
    logic [10:0] sh   [2];
    logic        txd  [2];

    exp_t        exp_q [2][$];
    int          starts_q [2][$];
    logic [7:0]  src_q [2][4][$];

    int vectors = 0;
    int miscompares = 0;

    logic [10:0] frame = 11'b110_1010_1010;

    uart_tx_arbiter #(.NUM_REQ(4), .IDW(3), .BURST_LEN(1), .TAG_BASE(8'hF0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv[0]), .req_data(rd[0]), .req_ready(rdy[0]),
        .tx_start(ts[0]), .tx_data(td[0]), .tx_busy(busy[0]), .grant_id(gid[0]), .active(act[0])
    );

    uart_tx_arbiter #(.NUM_REQ(4), .IDW(3), .BURST_LEN(3), .TAG_BASE(8'hF0)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv[1]), .req_data(rd[1]), .req_ready(rdy[1]),
        .tx_start(ts[1]), .tx_data(td[1]), .tx_busy(busy[1]), .grant_id(gid[1]), .active(act[1])
    );

    // Transmitter: busy for the 11 cycles after the start edge, one frame bit per cycle.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                cnt[k] <= 4'd0;
                sh[k]  <= '1;
            end else if (cnt[k] != 4'd0) begin
                cnt[k] <= cnt[k] - 4'd1;
                sh[k]  <= {1'b1, sh[k][10:1]};
            end else if (ts[k]) begin
                cnt[k] <= 4'd11;
                sh[k]  <= {2'b11, td[k], 1'b0};
            end
        end
    end

    assign busy[0] = (cnt[0] != 4'd0) | fb[0];
    assign busy[1] = (cnt[1] != 4'd0) | fb[1];
    assign txd[0]  = (cnt[0] != 4'd0) ? sh[0][0] : 1'b1;
    assign txd[1]  = (cnt[1] != 4'd0) ? sh[1][0] : 1'b1;

    task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        vectors++;
        if (act_v !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act_v, exp_v);
        end
    endtask

    task automatic fail_ev(input string name, input logic [31:0] act_v, input string req);
        vectors++;
        miscompares++;
        $display("FAIL %s: got %0h, required %s", name, act_v, req);
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            if (rst_n) begin
                if (ts[k] === 1'b1) begin
                    if (exp_q[k].size() == 0) begin
                        fail_ev($sformatf("unexpected_start_dut%0d", k), 32'(td[k]), "no start");
                    end else begin
                        e = exp_q[k].pop_front();
                        chk($sformatf("start_dut%0d{data,ready,gid}", k),
                            32'({td[k], rdy[k], gid[k]}), 32'(e));
                    end
                    if (rdy[k] != 4'd0) starts_q[k].push_back(cyc);
                end else if (rdy[k] !== 4'd0) begin
                    fail_ev($sformatf("ready_without_start_dut%0d", k), 32'(rdy[k]), "0");
                end
            end
        end
    end

    task automatic push_data(input int k, input int g, input logic [7:0] d);
        exp_t e;
        e.data = d;
        e.rdy  = 4'(1 << g);
        e.gid  = 3'(g);
        exp_q[k].push_back(e);
    endtask

    task automatic push_grant(input int k, input int g, input logic [7:0] d);
`ifdef UART_TX_ARB_TAG_EN
        exp_t e;
        e.data = 8'hF0 | 8'(g);
        e.rdy  = 4'd0;
        e.gid  = 3'(g);
        exp_q[k].push_back(e);
`endif
        push_data(k, g, d);
    endtask

    task automatic wait_ready(input int k, input int budget);
        int n = 0;
        while (rdy[k] == 4'd0) begin
            if (n >= budget) begin
                fail_ev("wait_ready_timeout", 32'(n), "req_ready pulse");
                return;
            end
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_idle(input int k, input int budget);
        int n = 0;
        while (act[k] !== 1'b0 || exp_q[k].size() != 0) begin
            if (n >= budget) begin
                fail_ev("wait_idle_timeout", 32'(exp_q[k].size()), "idle with empty scoreboard");
                return;
            end
            @(negedge clk);
            n++;
        end
    endtask

    // Sources present their queued bytes, advancing on each req_ready they see.
    task automatic serve(input int k, input int budget);
        int n = 0;
        for (int i = 0; i < 4; i++) begin
            if (src_q[k][i].size() != 0) begin
                rv[k][i]       = 1'b1;
                rd[k][8*i +: 8] = src_q[k][i][0];
            end
        end
        forever begin
            @(negedge clk);
            n++;
            for (int i = 0; i < 4; i++) begin
                if (rdy[k][i] && src_q[k][i].size() != 0) begin
                    void'(src_q[k][i].pop_front());
                    if (src_q[k][i].size() == 0) rv[k][i] = 1'b0;
                    else rd[k][8*i +: 8] = src_q[k][i][0];
                end
            end
            if (rv[k] == 4'd0 && act[k] == 1'b0 && exp_q[k].size() == 0) break;
            if (n >= budget) begin
                fail_ev("serve_timeout", 32'(exp_q[k].size()), "all bytes sent");
                break;
            end
        end
    endtask

    task automatic pulse_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int base;
        for (int k = 0; k < 2; k++) begin
            rv[k] = 4'd0;
            rd[k] = 32'd0;
            fb[k] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++)
            chk($sformatf("reset_outputs_dut%0d", k),
                32'({ts[k], rdy[k], td[k], gid[k], act[k]}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Lone request on source 2: one-cycle latency, then its frame on the line.
        rv[0]         = 4'b0100;
        rd[0][23:16]  = 8'h55;
        push_grant(0, 2, 8'h55);
        @(negedge clk);
        chk("t2_latency_tx_start", 32'(ts[0]), 32'd1);
        wait_ready(0, 40);
        chk("t2_ready_onehot", 32'(rdy[0]), 32'h4);
        rv[0] = 4'b0000;
        for (int b = 0; b < 11; b++) begin
            @(negedge clk);
            chk($sformatf("t2_txd_bit%0d", b), 32'(txd[0]), 32'(frame[b]));
        end
        wait_idle(0, 60);

        // Reset in the middle of the drain, then a clean retry.
        rv[0]        = 4'b0010;
        rd[0][15:8]  = 8'h3C;
        push_grant(0, 1, 8'h3C);
        @(negedge clk);
        wait_ready(0, 40);
        rv[0] = 4'b0000;
        repeat (4) @(negedge clk);
        chk("t1_in_drain_active", 32'(act[0]), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t1_after_reset_outputs", 32'({ts[0], rdy[0], td[0], gid[0], act[0]}), 32'd0);
        rst_n = 1'b1;
        rv[0] = 4'b0010;
        push_grant(0, 1, 8'h3C);
        @(negedge clk);
        wait_ready(0, 40);
        rv[0] = 4'b0000;
        wait_idle(0, 60);

        // All four held: strict rotation from index 0.
        pulse_reset();
        src_q[0][0].push_back(8'h10);
        src_q[0][0].push_back(8'h14);
        src_q[0][1].push_back(8'h11);
        src_q[0][2].push_back(8'h12);
        src_q[0][3].push_back(8'h13);
        push_grant(0, 0, 8'h10);
        push_grant(0, 1, 8'h11);
        push_grant(0, 2, 8'h12);
        push_grant(0, 3, 8'h13);
        push_grant(0, 0, 8'h14);
        base = starts_q[0].size();
        serve(0, 400);
        if (starts_q[0].size() < base + 5) begin
            fail_ev("t3_start_count", 32'(starts_q[0].size() - base), "5");
        end else begin
            for (int j = 1; j < 5; j++)
                chk($sformatf("t3_grant_gap%0d", j),
                    32'(starts_q[0][base+j] - starts_q[0][base+j-1]), 32'(GRANT_GAP));
        end

        // Busy from an external user blocks the grant; release starts one cycle later.
        fb[0]       = 1'b1;
        rv[0]       = 4'b0001;
        rd[0][7:0]  = 8'h5A;
        push_grant(0, 0, 8'h5A);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            chk($sformatf("t5_blocked_start%0d", j), 32'({ts[0], rdy[0]}), 32'd0);
        end
        fb[0] = 1'b0;
        @(negedge clk);
        chk("t5_release_latency", 32'(ts[0]), 32'd1);
        wait_ready(0, 40);
        rv[0] = 4'b0000;
        wait_idle(0, 60);

`ifdef UART_TX_ARB_TAG_EN
        // Tag byte precedes the data byte; only the data byte acknowledges the source.
        rv[0]        = 4'b1000;
        rd[0][31:24] = 8'hA5;
        push_grant(0, 3, 8'hA5);
        @(negedge clk);
        chk("t6_tag_byte", 32'({ts[0], td[0], rdy[0]}), 32'({1'b1, 8'hF3, 4'b0000}));
        wait_ready(0, 40);
        chk("t6_data_byte", 32'({ts[0], td[0], rdy[0]}), 32'({1'b1, 8'hA5, 4'b1000}));
        rv[0] = 4'b0000;
        wait_idle(0, 60);
`endif

        // Burst of three on source 1, then source 3, then source 1 finishes.
        src_q[1][1].push_back(8'h21);
        src_q[1][1].push_back(8'h22);
        src_q[1][1].push_back(8'h23);
        src_q[1][1].push_back(8'h24);
        src_q[1][1].push_back(8'h25);
        src_q[1][3].push_back(8'h31);
        push_grant(1, 1, 8'h21);
        push_data(1, 1, 8'h22);
        push_data(1, 1, 8'h23);
        push_grant(1, 3, 8'h31);
        push_grant(1, 1, 8'h24);
        push_data(1, 1, 8'h25);
        base = starts_q[1].size();
        serve(1, 600);
        if (starts_q[1].size() < base + 6) begin
            fail_ev("t4_start_count", 32'(starts_q[1].size() - base), "6");
        end else begin
            chk("t4_burst_gap", 32'(starts_q[1][base+1] - starts_q[1][base]), 32'(BURST_GAP));
            chk("t4_regrant_gap", 32'(starts_q[1][base+3] - starts_q[1][base+2]), 32'(GRANT_GAP));
        end

        repeat (5) @(negedge clk);
        for (int k = 0; k < 2; k++)
            if (exp_q[k].size() != 0)
                fail_ev($sformatf("leftover_expected_dut%0d", k), 32'(exp_q[k].size()), "0");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
